// File: rtl/truth_table_sequencer.sv
// Stimulus/response checker for the logic pair a = ~x | y, b = x & y.
// It sweeps x,y through 00..11 PASSES times, scores each sampled vector and reports a verdict.
module truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x,
    output logic       y,
    input  logic       a_in,
    input  logic       b_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx,
    output logic [1:0] state_dbg
);

    localparam int S_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int P_EFF = (PASSES < 1) ? 1 : PASSES;
    localparam int SW    = $clog2(S_EFF + 1);
    localparam int PW    = $clog2(P_EFF + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(S_EFF);
    localparam logic [PW-1:0] LAST_PASS   = PW'(P_EFF - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] settle_cnt, settle_nxt;
    logic [PW-1:0] pass_cnt, pass_cnt_nxt;
    logic [1:0]    vec_nxt;
    logic          x_nxt, y_nxt, pass_nxt;
    logic [7:0]    err_nxt, err_now;
    logic [3:0]    mask_nxt, mask_now;
    logic          mismatch;

    // start has no ready/ack: it is a level sampled only while IDLE, and
    // any assertion outside IDLE is dropped rather than queued.
    always_comb begin
        state_nxt    = state;
        settle_nxt   = settle_cnt;
        pass_cnt_nxt = pass_cnt;
        vec_nxt      = vec_idx;
        x_nxt        = x;
        y_nxt        = y;
        pass_nxt     = pass;
        err_nxt      = err_count;
        mask_nxt     = fail_mask;

        // A vector scores at most one mismatch even when both outputs are wrong.
        mismatch = (a_in != (~x | y)) | (b_in != (x & y));
        err_now  = (mismatch && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        mask_now = mismatch ? (fail_mask | (4'b0001 << vec_idx)) : fail_mask;

        case (state)
            IDLE: begin
                x_nxt = 1'b0;
                y_nxt = 1'b0;
                if (start) begin
                    err_nxt      = 8'd0;
                    mask_nxt     = 4'd0;
                    pass_cnt_nxt = '0;
                    vec_nxt      = 2'd0;
                    settle_nxt   = SETTLE_LOAD;
                    state_nxt    = SETTLE;
                end
            end
            SETTLE: begin
                settle_nxt = settle_cnt - SW'(1);
                if (settle_cnt <= SW'(1)) state_nxt = CHECK;
            end
            CHECK: begin
                err_nxt    = err_now;
                mask_nxt   = mask_now;
                settle_nxt = SETTLE_LOAD;
                if (vec_idx != 2'd3) begin
                    vec_nxt   = vec_idx + 2'd1;
                    x_nxt     = vec_nxt[1];
                    y_nxt     = vec_nxt[0];
                    state_nxt = SETTLE;
                end else if (pass_cnt < LAST_PASS) begin
                    pass_cnt_nxt = pass_cnt + PW'(1);
                    vec_nxt      = 2'd0;
                    x_nxt        = 1'b0;
                    y_nxt        = 1'b0;
                    state_nxt    = SETTLE;
                end else begin
                    pass_nxt  = (err_now == 8'd0);
                    vec_nxt   = 2'd0;
                    x_nxt     = 1'b0;
                    y_nxt     = 1'b0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                x_nxt     = 1'b0;
                y_nxt     = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            vec_idx    <= 2'd0;
            x          <= 1'b0;
            y          <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'd0;
            fail_mask  <= 4'd0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            pass_cnt   <= pass_cnt_nxt;
            vec_idx    <= vec_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            pass       <= pass_nxt;
            err_count  <= err_nxt;
            fail_mask  <= mask_nxt;
        end
    end

    assign busy      = (state == SETTLE) || (state == CHECK);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: four instances with different parameters, each
// looped back through a logic pair whose outputs can be corrupted per vector.
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_w [4];
    logic       x_w     [4];
    logic       y_w     [4];
    logic       a_w     [4];
    logic       b_w     [4];
    logic       busy_w  [4];
    logic       done_w  [4];
    logic       pass_w  [4];
    logic [7:0] err_w   [4];
    logic [3:0] mask_w  [4];
    logic [1:0] vidx_w  [4];
    logic [1:0] st_w    [4];
    logic [3:0] ca      [4];
    logic [3:0] cb      [4];

    // Logic pair per instance; ca/cb bit k flips a/b while vector k = {x,y} is applied.
    for (genvar g = 0; g < 4; g++) begin : g_pair
        assign a_w[g] = (~x_w[g] | y_w[g]) ^ ca[g][{x_w[g], y_w[g]}];
        assign b_w[g] = (x_w[g] & y_w[g]) ^ cb[g][{x_w[g], y_w[g]}];
    end

    truth_table_sequencer #(.SETTLE_CYCLES(1), .PASSES(1)) u0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .x(x_w[0]), .y(y_w[0]),
        .a_in(a_w[0]), .b_in(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_count(err_w[0]), .fail_mask(mask_w[0]),
        .vec_idx(vidx_w[0]), .state_dbg(st_w[0]));
    truth_table_sequencer #(.SETTLE_CYCLES(1), .PASSES(2)) u1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .x(x_w[1]), .y(y_w[1]),
        .a_in(a_w[1]), .b_in(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_count(err_w[1]), .fail_mask(mask_w[1]),
        .vec_idx(vidx_w[1]), .state_dbg(st_w[1]));
    truth_table_sequencer #(.SETTLE_CYCLES(3), .PASSES(1)) u2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .x(x_w[2]), .y(y_w[2]),
        .a_in(a_w[2]), .b_in(b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .err_count(err_w[2]), .fail_mask(mask_w[2]),
        .vec_idx(vidx_w[2]), .state_dbg(st_w[2]));
    truth_table_sequencer #(.SETTLE_CYCLES(1), .PASSES(70)) u3 (
        .clk(clk), .rst(rst), .start(start_w[3]), .x(x_w[3]), .y(y_w[3]),
        .a_in(a_w[3]), .b_in(b_w[3]), .busy(busy_w[3]), .done(done_w[3]),
        .pass(pass_w[3]), .err_count(err_w[3]), .fail_mask(mask_w[3]),
        .vec_idx(vidx_w[3]), .state_dbg(st_w[3]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: every corrupted vector scores once per pass; count saturates at 255.
    function automatic void model(input logic [3:0] ca_v, input logic [3:0] cb_v, input int p,
                                  output logic [7:0] e, output logic [3:0] m, output logic ps);
        int n;
        m  = ca_v | cb_v;
        n  = p * $countones(m);
        e  = (n > 255) ? 8'd255 : 8'(n);
        ps = (n == 0);
    endfunction

    task automatic check_reset_state(input int i, input string tag);
        chk({tag, ".x"}, 32'(x_w[i]), 0);
        chk({tag, ".y"}, 32'(y_w[i]), 0);
        chk({tag, ".vec_idx"}, 32'(vidx_w[i]), 0);
        chk({tag, ".busy"}, 32'(busy_w[i]), 0);
        chk({tag, ".done"}, 32'(done_w[i]), 0);
        chk({tag, ".pass"}, 32'(pass_w[i]), 0);
        chk({tag, ".err_count"}, 32'(err_w[i]), 0);
        chk({tag, ".fail_mask"}, 32'(mask_w[i]), 0);
    endtask

    // One full run on instance i; checks latency, the applied x,y sequence and the verdict.
    task automatic do_run(input int i, input int s, input int p, input logic [7:0] e_err,
                          input logic [3:0] e_mask, input logic e_pass, input string tag);
        logic [1:0] exp_q[$];
        logic [1:0] obs_q[$];
        int lat;
        int vbad;
        bit seen;
        bit seq_ok;
        vbad = 0;
        seen = 0;
        for (int pp = 0; pp < p; pp++)
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < s + 1; c++) exp_q.push_back(2'(k));
        @(negedge clk);
        start_w[i] = 1'b1;
        @(negedge clk);
        start_w[i] = 1'b0;
        lat = 0;
        while (!seen && lat < 3000) begin
            if (busy_w[i]) begin
                obs_q.push_back({x_w[i], y_w[i]});
                if (vidx_w[i] !== {x_w[i], y_w[i]}) vbad++;
            end
            if (done_w[i]) seen = 1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, ".done_seen"}, 32'(seen), 1);
        chk({tag, ".latency"}, 32'(lat), 32'(4 * p * (s + 1)));
        chk({tag, ".xy_at_done"}, 32'({x_w[i], y_w[i], busy_w[i]}), 0);
        seq_ok = (obs_q.size() == exp_q.size());
        for (int n = 0; n < obs_q.size() && seq_ok; n++)
            if (obs_q[n] !== exp_q[n]) seq_ok = 0;
        chk({tag, ".xy_sequence"}, 32'(seq_ok), 1);
        chk({tag, ".vec_idx_tracks_xy"}, 32'(vbad), 0);
        @(negedge clk);
        chk({tag, ".done_width"}, 32'(done_w[i]), 0);
        chk({tag, ".err_count"}, 32'(err_w[i]), 32'(e_err));
        chk({tag, ".fail_mask"}, 32'(mask_w[i]), 32'(e_mask));
        chk({tag, ".pass"}, 32'(pass_w[i]), 32'(e_pass));
    endtask

    typedef struct {
        logic [3:0] ca_v;
        logic [3:0] cb_v;
        logic [7:0] e_err;
        logic [3:0] e_mask;
        logic       e_pass;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [7:0] m_err;
        logic [3:0] m_mask;
        logic       m_pass;
        int         dcount;
        int         dpos;
        int         inst;

        tbl[0] = '{4'b0000, 4'b0000, 8'd0, 4'b0000, 1'b1};  // correct pair
        tbl[1] = '{4'b0000, 4'b1000, 8'd1, 4'b1000, 1'b0};  // b stuck at 0
        tbl[2] = '{4'b1111, 4'b0000, 8'd4, 4'b1111, 1'b0};  // a inverted
        tbl[3] = '{4'b0011, 4'b0110, 8'd3, 4'b0111, 1'b0};  // both wrong on vec 1 counts once
        tbl[4] = '{4'b0000, 4'b1111, 8'd4, 4'b1111, 1'b0};  // b inverted

        for (int i = 0; i < 4; i++) begin
            start_w[i] = 1'b0;
            ca[i] = 4'd0;
            cb[i] = 4'd0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state(0, "reset");
        rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            ca[0] = tbl[r].ca_v;
            cb[0] = tbl[r].cb_v;
            do_run(0, 1, 1, tbl[r].e_err, tbl[r].e_mask, tbl[r].e_pass, $sformatf("tbl%0d", r));
        end

        ca[1] = 4'b1111; cb[1] = 4'b0000;
        do_run(1, 1, 2, 8'd8, 4'b1111, 1'b0, "a_inv_p2");
        do_run(2, 3, 1, 8'd0, 4'b0000, 1'b1, "settle3");
        ca[3] = 4'b1111; cb[3] = 4'b0000;
        do_run(3, 1, 70, 8'd255, 4'b1111, 1'b0, "saturate");

        // start re-pulsed during SETTLE of vector 1 must be ignored
        ca[0] = 4'd0; cb[0] = 4'd0;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("restart.in_vec1", 32'(vidx_w[0]), 1);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        dcount = 0;
        dpos = -1;
        for (int n = 3; n < 25; n++) begin
            if (done_w[0]) begin
                dcount++;
                if (dpos < 0) dpos = n;
            end
            @(negedge clk);
        end
        chk("restart.done_count", 32'(dcount), 1);
        chk("restart.done_edge", 32'(dpos), 8);
        chk("restart.pass", 32'(pass_w[0]), 1);

        // reset during CHECK of vector 2
        @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst.vec_before", 32'(vidx_w[0]), 2);
        chk("midrst.busy_before", 32'(busy_w[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state(0, "midrst");
        rst = 1'b0;
        do_run(0, 1, 1, 8'd0, 4'b0000, 1'b1, "after_rst");

        // randomized corruption patterns against the reference model
        for (int t = 0; t < 12; t++) begin
            inst = t % 2;
            ca[inst] = 4'($urandom_range(0, 15));
            cb[inst] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) cb[inst] = 4'd0;
            if ($urandom_range(0, 3) == 0) ca[inst] = 4'd0;
            model(ca[inst], cb[inst], inst + 1, m_err, m_mask, m_pass);
            do_run(inst, 1, inst + 1, m_err, m_mask, m_pass, $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Self-checking stimulus/response stage that sits directly around the two-input logic pair (a = ~x | y, b = x & y).
- Upstream role: drives x and y through the four input combinations in binary order 00, 01, 10, 11.
- Downstream role: samples the pair's outputs a and b after a programmable settle time and compares them against the expected values.
- Accumulates a mismatch count and a per-vector failure mask, then pulses done with a pass/fail verdict.

Parameters:
SETTLE_CYCLES, 1, cycles to hold each vector before sampling; legal range >= 1; a value of 0 behaves as 1.
PASSES, 1, number of full 4-vector sweeps per run; legal range >= 1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
start  input  1  begin a run; sampled only in IDLE.
x  output  1  stimulus to logic pair; registered; equals vec_idx[1].
y  output  1  stimulus to logic pair; registered; equals vec_idx[0].
a_in  input  1  implication output returned from logic pair.
b_in  input  1  AND output returned from logic pair.
busy  output  1  high in SETTLE and CHECK.
done  output  1  one-cycle pulse at end of run.
pass  output  1  1 when the last completed run had err_count == 0.
err_count  output  8  mismatch count for the current/last run; saturates at 255.
fail_mask  output  4  bit k set if vector k mismatched in any pass.
vec_idx  output  2  current vector index.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, x=0, y=0, vec_idx=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, internal pass and settle counters=0.
- Reset has priority over every other input, including a run in progress: the block returns to IDLE with all reset values in one edge.
- IDLE:
  - x=y=0; err_count, fail_mask and pass hold the previous run's results.
  - start=1 → clear err_count, fail_mask and pass counter; vec_idx=0; x,y=00; settle counter=SETTLE_CYCLES; go to SETTLE.
- SETTLE:
  - Decrement the settle counter each cycle; stay for SETTLE_CYCLES cycles total, then go to CHECK.
  - x and y are stable throughout.
- CHECK (exactly one cycle):
  - exp_a = ~x | y; exp_b = x & y.
  - Mismatch = (a_in != exp_a) | (b_in != exp_b); a vector counts as at most 1 mismatch even if both outputs are wrong.
  - On mismatch: err_count = min(err_count+1, 255); fail_mask[vec_idx] = 1.
  - If vec_idx != 3: vec_idx++, drive the new x,y, reload the settle counter, go to SETTLE.
  - If vec_idx == 3 and the pass counter < PASSES-1: pass counter++, vec_idx=0, x,y=00, go to SETTLE.
  - If vec_idx == 3 and this is the final pass: go to DONE. pass is computed from err_count including this check's result.
- DONE (one cycle): done=1, busy=0, x=y=0; next state IDLE.
- start while in SETTLE, CHECK or DONE is ignored; no queuing.
- Latency: with start sampled at edge E0, done is high in the cycle after edge E0 + 4·PASSES·(SETTLE_CYCLES+1).
  - Example: defaults give done after E8, i.e. 8 edges after the start edge.
- a_in and b_in are ignored outside CHECK.
- No combinational path from a_in/b_in to any output.

Test Plan:
- Correct logic pair, defaults, start pulse at E0:
  - x,y step through 00,01,10,11.
  - done pulses 8 edges after E0.
  - pass=1, err_count=0, fail_mask=0000.
- b_in stuck at 0 → only vector 11 fails: err_count=1, fail_mask=1000, pass=0.
- a_in forced to the inverse of the correct value, PASSES=2 → err_count=8, fail_mask=1111, done 16 edges after start.
- SETTLE_CYCLES=3, correct pair:
  - each vector is held 3 cycles before its CHECK cycle;
  - done 16 edges after start; pass=1.
- start re-pulsed during SETTLE of vector 1 → ignored: the run completes unchanged, with exactly one done pulse.
- rst asserted during the CHECK of vector 2 → next cycle all outputs at reset values; a new start then yields a clean run with pass=1.
- PASSES=70 with a always inverted → 280 mismatches; err_count saturates at 255, pass=0.
